// File: rtl/ps2_key_state_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_state_decoder_if
//   Groups the scan-code input bus and the key-level outputs of
//   ps2_key_state_decoder.
//   master : the side that produces scan codes (PS/2 receiver or a bench).
//            It drives code_valid, code and hold, and reads the key lines.
//   slave  : the decoder itself. It reads the code bus and drives
//            key0..key3 and key_event.
//   Signals:
//     code_valid  one-cycle strobe; code holds a complete byte
//     code[7:0]   set-2 scan-code byte
//     hold        sustain request (meaningful only in PS2_HOLD_EN builds)
//     key0..key3  registered key-held levels
//     key_event   one-cycle pulse whenever any keyN changes
// ---------------------------------------------------------------------------
interface ps2_key_state_decoder_if;
  logic       code_valid;
  logic [7:0] code;
  logic       hold;
  logic       key0;
  logic       key1;
  logic       key2;
  logic       key3;
  logic       key_event;

  modport master (
    output code_valid, code, hold,
    input  key0, key1, key2, key3, key_event
  );

  modport slave (
    input  code_valid, code, hold,
    output key0, key1, key2, key3, key_event
  );
endinterface

// File: rtl/ps2_key_state_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_state_decoder
//   Turns a stream of PS/2 set-2 scan codes into four level-sensitive key
//   lines for the arpeggiator. A small FSM tracks the F0 (break) and E0
//   (extended) prefixes; each mapped key has a registered pressed bit, and
//   key_event pulses for one cycle whenever the key vector changes.
//   Prefix states give up and return to IDLE after TIMEOUT_CYCLES cycles
//   without a new byte.
//
//   Optional feature macro: PS2_HOLD_EN
//     Defined  : a break received while hold=1 parks the key in a pending
//                (sustained) bit; outputs are pressed|pending and all
//                pending bits drop on the first cycle hold is sampled 0.
//     Undefined: hold is ignored and outputs equal the pressed state.
//
//   Ports:
//     CLK    system clock
//     RESET  synchronous, active-high reset
//     bus    ps2_key_state_decoder_if.slave (code_valid, code, hold in;
//            key0..key3, key_event out)
// ---------------------------------------------------------------------------
module ps2_key_state_decoder #(
  parameter logic [7:0] KEY0_CODE      = 8'h1C,
  parameter logic [7:0] KEY1_CODE      = 8'h1B,
  parameter logic [7:0] KEY2_CODE      = 8'h23,
  parameter logic [7:0] KEY3_CODE      = 8'h2B,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                        CLK,
  input  logic                        RESET,
  ps2_key_state_decoder_if.slave      bus
);

  localparam logic [7:0]  CODE_BREAK = 8'hF0;
  localparam logic [7:0]  CODE_EXT   = 8'hE0;
  localparam logic [7:0]  CODE_BAT   = 8'hAA;
  localparam logic [7:0]  CODE_FAIL  = 8'hFC;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] KEY_CODES  = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  pressed_q, pressed_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  keys_q, keys_d;
  logic        key_event_q, key_event_d;
  logic [3:0]  match;

  // One comparator per key; duplicate codes simply light up several bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    assign match[gi] = (bus.code == KEY_CODES[gi*8 +: 8]);
  end

`ifndef PS2_HOLD_EN
  logic unused_hold;
  assign unused_hold = bus.hold;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    pressed_d = pressed_q;
    pending_d = pending_q;

    if (bus.code_valid) begin
      // A received byte always wins over a coincident timeout expiry.
      case (state_q)
        IDLE: begin
          if (bus.code == CODE_BREAK) begin
            state_d = BREAK;
          end else if (bus.code == CODE_EXT) begin
            state_d = EXT;
          end else if (bus.code == CODE_BAT || bus.code == CODE_FAIL) begin
            pressed_d = '0;
            pending_d = '0;
          end else begin
            pressed_d = pressed_q | match;
            pending_d = pending_q & ~match;
          end
        end
        BREAK: begin
          if (bus.code != CODE_BREAK && bus.code != CODE_EXT) begin
`ifdef PS2_HOLD_EN
            // Only a key that is actually down can be sustained.
            if (bus.hold) pending_d = pending_q | (match & pressed_q);
`endif
            pressed_d = pressed_q & ~match;
          end
          state_d = IDLE;
        end
        EXT: begin
          state_d = (bus.code == CODE_BREAK) ? EXT_BREAK : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

`ifdef PS2_HOLD_EN
    if (!bus.hold) pending_d = '0;
`else
    pending_d = '0;
`endif

    keys_d      = pressed_d | pending_d;
    key_event_d = (keys_d != keys_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pressed_q   <= '0;
      pending_q   <= '0;
      keys_q      <= '0;
      key_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pressed_q   <= pressed_d;
      pending_q   <= pending_d;
      keys_q      <= keys_d;
      key_event_q <= key_event_d;
    end
  end

  assign bus.key0      = keys_q[0];
  assign bus.key1      = keys_q[1];
  assign bus.key2      = keys_q[2];
  assign bus.key3      = keys_q[3];
  assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_state_decoder
//   Self-checking bench for ps2_key_state_decoder (TIMEOUT_CYCLES=8).
//   Each driven cycle updates a behavioural model and pushes the expected
//   {key_event, key3..key0} into a queue; the value is popped and compared
//   just after the following clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_state_decoder;

  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ps2_key_state_decoder_if bus ();

  ps2_key_state_decoder #(
    .KEY0_CODE(8'h1C), .KEY1_CODE(8'h1B), .KEY2_CODE(8'h23), .KEY3_CODE(8'h2B),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int ev_seen  = 0;

  logic [4:0] exp_q[$];

  // Behavioural model
  int         m_state;   // 0 idle, 1 break, 2 ext, 3 ext-break
  int         m_cnt;
  logic [3:0] m_pressed;
  logic [3:0] m_pending;
  logic [3:0] m_out;
  logic [7:0] m_codes [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [7:0] c, input logic h);
    logic [3:0] hit;
    logic [3:0] np, nd;
    logic       ev;
    for (int i = 0; i < 4; i++) hit[i] = (c == m_codes[i]);
    if (rst) begin
      m_state = 0; m_cnt = 0; m_pressed = 0; m_pending = 0; m_out = 0;
      exp_q.push_back(5'b0);
      return;
    end
    np = m_pressed;
    nd = m_pending;
    if (v) begin
      m_cnt = 0;
      if (m_state == 0) begin
        if (c == 8'hF0)                   m_state = 1;
        else if (c == 8'hE0)              m_state = 2;
        else if (c == 8'hAA || c == 8'hFC) begin np = 0; nd = 0; end
        else begin np = np | hit; nd = nd & ~hit; end
      end else if (m_state == 1) begin
        if (c != 8'hF0 && c != 8'hE0) begin
          if (h) nd = nd | (hit & m_pressed);
          np = np & ~hit;
        end
        m_state = 0;
      end else if (m_state == 2) begin
        m_state = (c == 8'hF0) ? 3 : 0;
      end else begin
        m_state = 0;
      end
    end else if (m_state != 0) begin
      if (m_cnt == TO - 1) begin m_state = 0; m_cnt = 0; end
      else m_cnt++;
    end else begin
      m_cnt = 0;
    end
`ifdef PS2_HOLD_EN
    if (!h) nd = 0;
`else
    nd = 0;
`endif
    m_pressed = np;
    m_pending = nd;
    ev = ((np | nd) != m_out);
    m_out = np | nd;
    exp_q.push_back({ev, m_out});
  endtask

  // One clock cycle: drive on the falling edge, compare after the rising edge.
  task automatic cyc(input string tag, input logic rst, input logic v,
                     input logic [7:0] c, input logic h);
    logic [4:0] exp_v;
    logic [4:0] got_v;
    @(negedge CLK);
    RESET = rst; bus.code_valid = v; bus.code = c; bus.hold = h;
    model_step(rst, v, c, h);
    @(posedge CLK);
    #1;
    got_v = {bus.key_event, bus.key3, bus.key2, bus.key1, bus.key0};
    if (bus.key_event) ev_seen++;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check_val(tag, {27'd0, got_v}, {27'd0, exp_v});
    end
  endtask

  task automatic send(input string tag, input logic [7:0] c, input logic h);
    cyc(tag, 1'b0, 1'b1, c, h);
  endtask

  task automatic idle(input string tag, input int n, input logic h);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 8'h00, h);
  endtask

  task automatic keys_are(input string tag, input logic [3:0] want);
    check_val(tag, {28'd0, bus.key3, bus.key2, bus.key1, bus.key0}, {28'd0, want});
  endtask

  initial begin
    RESET = 1'b1; bus.code_valid = 1'b0; bus.code = 8'h00; bus.hold = 1'b0;
    m_state = 0; m_cnt = 0; m_pressed = 0; m_pending = 0; m_out = 0;

    // Reset overrides a simultaneous make code
    cyc("reset0", 1'b1, 1'b1, 8'h1C, 1'b0);
    cyc("reset1", 1'b1, 1'b1, 8'h1C, 1'b0);
    keys_are("reset_keys", 4'h0);
    idle("post_reset", 2, 1'b0);

    // Make then break
    send("make_1c", 8'h1C, 1'b0);
    keys_are("make_key0", 4'h1);
    check_val("make_event", {31'd0, bus.key_event}, 32'd1);
    send("brk_f0", 8'hF0, 1'b0);
    send("brk_1c", 8'h1C, 1'b0);
    keys_are("break_key0", 4'h0);
    check_val("break_event", {31'd0, bus.key_event}, 32'd1);
    idle("gap1", 1, 1'b0);

    // Chord with typematic repeat, then self-test code clears everything
    ev_seen = 0;
    send("chord_1c", 8'h1C, 1'b0);
    send("chord_23", 8'h23, 1'b0);
    send("rep_1c_a", 8'h1C, 1'b0);
    send("rep_1c_b", 8'h1C, 1'b0);
    keys_are("chord_keys", 4'h5);
    check_val("chord_events", ev_seen, 32'd2);
    send("self_test", 8'hAA, 1'b0);
    keys_are("aa_clear", 4'h0);
    check_val("aa_event", {31'd0, bus.key_event}, 32'd1);
    send("stray_break_f0", 8'hF0, 1'b0);
    send("stray_break_23", 8'h23, 1'b0);
    check_val("stray_break_event", {31'd0, bus.key_event}, 32'd0);

    // Extended codes are filtered, FSM returns to IDLE
    ev_seen = 0;
    send("ext_e0", 8'hE0, 1'b0);
    send("ext_1c", 8'h1C, 1'b0);
    send("extb_e0", 8'hE0, 1'b0);
    send("extb_f0", 8'hF0, 1'b0);
    send("extb_1c", 8'h1C, 1'b0);
    send("unmapped", 8'h7A, 1'b0);
    keys_are("ext_nochange", 4'h0);
    check_val("ext_events", ev_seen, 32'd0);
    send("ext_then_1b", 8'h1B, 1'b0);
    keys_are("ext_then_key1", 4'h2);

    // Timeout: byte after TO idle cycles is a make
    send("to_clr_aa", 8'hAA, 1'b0);
    send("to_f0", 8'hF0, 1'b0);
    idle("to_wait", TO, 1'b0);
    send("to_1b_make", 8'h1B, 1'b0);
    keys_are("timeout_make", 4'h2);
    // Byte on the expiry cycle is still a break
    send("to2_f0", 8'hF0, 1'b0);
    idle("to2_wait", TO - 1, 1'b0);
    send("to2_1b_break", 8'h1B, 1'b0);
    keys_are("expiry_break", 4'h0);

    // Reset discards a pending break prefix
    send("rst_f0", 8'hF0, 1'b0);
    cyc("rst_mid", 1'b1, 1'b0, 8'h00, 1'b0);
    send("rst_1c_make", 8'h1C, 1'b0);
    keys_are("reset_prefix", 4'h1);
    send("hold_clr_aa", 8'hAA, 1'b0);

    // Sustain
    send("hold_2b", 8'h2B, 1'b1);
    send("hold_f0", 8'hF0, 1'b1);
    send("hold_brk_2b", 8'h2B, 1'b1);
`ifdef PS2_HOLD_EN
    keys_are("hold_sustain", 4'h8);
    idle("hold_keep", 1, 1'b1);
    idle("hold_release", 1, 1'b0);
    keys_are("hold_dropped", 4'h0);
    check_val("hold_drop_event", {31'd0, bus.key_event}, 32'd1);
`else
    keys_are("nohold_drop", 4'h0);
    check_val("nohold_event", {31'd0, bus.key_event}, 32'd1);
    idle("nohold_release", 1, 1'b0);
    keys_are("nohold_after", 4'h0);
`endif
    idle("tail", 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_state_decoder.md
Name: ps2_key_state_decoder

Overview:
- Sits upstream of the arpeggiator/voice logic. It is the producer of the four level-sensitive key lines (key0..key3) that the arpeggiator consumes.
- Consumes a byte stream of PS/2 set-2 scan codes from the PS/2 receiver and tracks make/break prefixes in a small FSM.
- Maintains a registered pressed/released state bit for each of four configurable keys, plus a one-cycle change strobe.

Parameters:
- KEY0_CODE, 8'h1C, set-2 make code mapped to key0 ('A')
- KEY1_CODE, 8'h1B, make code mapped to key1 ('S')
- KEY2_CODE, 8'h23, make code mapped to key2 ('D')
- KEY3_CODE, 8'h2B, make code mapped to key3 ('F')
- TIMEOUT_CYCLES, 50000, CLK cycles a prefix state may wait for its next byte before abandoning; range 1..65535, 16-bit counter

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- code_valid  input  1  one-cycle strobe: code holds a complete received byte
- code  input  8  scan-code byte, sampled only when code_valid=1
- hold  input  1  sustain request; used only when PS2_HOLD_EN is defined, ignored otherwise
- key0, key1, key2, key3  output  1 each  registered key-held levels to the arpeggiator
- key_event  output  1  one-cycle pulse the cycle any keyN output changes

Behaviour:
- Reset (RESET=1 at posedge CLK):
  - state=IDLE, timeout counter=0
  - key0..key3=0, key_event=0, pending-release bits=0
  - RESET overrides code_valid in the same cycle; a mid-sequence prefix is discarded.
- Latency: the keyN update is visible on the first posedge after the posedge sampling code_valid=1 (1-cycle registered). key_event is asserted in that same cycle.
- FSM states and transitions on code_valid=1:
  - IDLE:
    - 8'hF0 -> BREAK
    - 8'hE0 -> EXT
    - 8'hAA or 8'hFC (keyboard self-test result) -> clear all keys, stay IDLE
    - code matching KEYn_CODE -> set keyN=1, stay IDLE
    - any other code -> ignore, stay IDLE
  - BREAK:
    - code matching KEYn_CODE -> clear keyN=0
    - 8'hF0 or 8'hE0 -> treated as unmapped
    - always -> IDLE
  - EXT:
    - 8'hF0 -> EXT_BREAK
    - any other byte -> consumed, no key change, -> IDLE
  - EXT_BREAK: any byte -> consumed, no key change, -> IDLE. Extended keys are never mapped.
- Typematic repeat: repeated make codes for a held key are idempotent. keyN stays 1 and key_event is not pulsed.
- Break code for a key that is not held: no change, no key_event.
- Keys are independent; any combination of the four may be held simultaneously.
- If parameters give two keys the same code, both bits track that code.
- Timeout counter:
  - Counts only in BREAK, EXT, EXT_BREAK; cleared on every code_valid and in IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no code_valid: state -> IDLE, keys unchanged.
  - If code_valid and expiry coincide, the byte is processed in the current state (valid wins).
- key_event=1 iff the registered key vector differs from its previous value; otherwise 0.
- code is ignored while code_valid=0. Back-to-back code_valid on consecutive cycles is supported.

Optional Feature:
- Macro: PS2_HOLD_EN
- Defined (sustain/latch for the arpeggiator):
  - Internal 4-bit pending vector; keyN output = pressed[N] | pending[N].
  - Break for key N while hold=1: pressed[N]=0, pending[N]=1, output unchanged.
  - Make for key N clears pending[N].
  - On the cycle hold is sampled 0, all pending bits clear, so outputs drop 1 cycle later.
  - 8'hAA/8'hFC clears both pressed and pending.
  - key_event follows the output vector.
- Undefined: hold is ignored, there are no pending registers, and outputs equal pressed state.

Test Plan:
- Reset: RESET=1 for 2 cycles with code_valid=1, code=8'h1C -> key0..3=0, key_event=0 throughout.
- Make then break: 1C; F0,1C -> key0=1 one cycle after the 1C strobe with key_event pulse; key0=0 one cycle after the second 1C with key_event pulse.
- Chord and repeat: 1C,23,1C,1C -> key0=1,key2=1; key_event pulses on exactly 2 cycles; a following AA -> all keys 0 with one key_event pulse.
- Extended filter: E0,1C; E0,F0,1C; then 7A (unmapped) -> no key change, no key_event, FSM back in IDLE (next 1B sets key1).
- Timeout (TIMEOUT_CYCLES=8): F0, idle 8 cycles, then 1B -> key1=1 (treated as make, not break). Repeat with the byte on cycle 7 -> byte processed as break.
- PS2_HOLD_EN: hold=1, 2B, F0,2B -> key3 stays 1. hold=0 -> key3=0 one cycle later with key_event. With the macro undefined, the same stimulus drops key3 immediately after the break.
